onehot_encoder_pipe: RTL and testbench

- Parametrised, registered successor to the team's 4-to-2 one-hot encoder.
- Generalised to IN_W inputs, with a selectable strict one-hot or priority encoding mode.
- Flags zero and multi-hot input words, keeps a saturating error counter, and sits between a producer and a consumer behind valid/ready handshakes with one cycle of latency.
- Used wherever a request or grant vector must be turned into an index for downstream logic.

---
 rtl/onehot_encoder_pipe.sv | 94 +++++++++
 tb/tb_onehot_encoder_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_pipe.sv
// Registered IN_W-to-index encoder with strict one-hot or priority modes,
// zero/multi-hot flags, a saturating error counter and valid/ready handshakes.
module onehot_encoder_pipe #(
   parameter  int IN_W     = 8,
   parameter  int MODE     = 0,
   parameter  int PRIO_MSB = 1,
   parameter  int CNT_W    = 8,
   localparam int OUT_W    = $clog2(IN_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_code,
   output logic             out_zero,
   output logic             out_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_code_q, out_code_d;
   logic             out_zero_q, out_zero_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             accept;
   logic [OUT_W-1:0] hi_idx, lo_idx;
   logic             enc_zero, enc_multi, enc_err;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // hi_idx ends on the highest set bit, lo_idx on the lowest.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (in_data[i]) hi_idx = OUT_W'(i);
         if (in_data[IN_W-1-i]) lo_idx = OUT_W'(IN_W-1-i);
      end
      enc_zero  = ~|in_data;
      enc_multi = |(in_data & (in_data - 1'b1));
      enc_err   = enc_multi && (MODE == 0);
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_zero_d  = out_zero_q;
      out_err_d   = out_err_q;
      err_cnt_d   = err_cnt_q;
      // in_data is only looked at under accept so X on idle cycles stays out of state.
      if (accept) begin
         out_valid_d = 1'b1;
         out_code_d  = (PRIO_MSB != 0) ? hi_idx : lo_idx;
         out_zero_d  = enc_zero;
         out_err_d   = enc_err;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (accept && enc_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_zero_q  <= 1'b0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_zero_q  <= out_zero_d;
         out_err_q   <= out_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_zero  = out_zero_q;
   assign out_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: three configurations share one stimulus stream
// and are checked every cycle against a behavioural model plus literal pins.
module tb_onehot_encoder_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       out_ready = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       in_ready_w  [3];
   logic       out_valid_w [3];
   logic [2:0] code_w      [3];
   logic       zero_w      [3];
   logic       err_w       [3];
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int errors = 0;
   int checks = 0;

   // Per-instance configuration: dut0 strict/MSB, dut1 priority/LSB, dut2 strict/MSB with 2-bit counter.
   int cfg_mode [3] = '{0, 1, 0};
   int cfg_prio [3] = '{1, 0, 1};
   int cfg_cmax [3] = '{255, 255, 3};

   always #5 clk = ~clk;

   onehot_encoder_pipe #(.IN_W(8), .MODE(0), .PRIO_MSB(1), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
      .out_code(code_w[0]), .out_zero(zero_w[0]), .out_err(err_w[0]),
      .clr_cnt(clr_cnt), .err_cnt(cnt0));

   onehot_encoder_pipe #(.IN_W(8), .MODE(1), .PRIO_MSB(0), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
      .out_code(code_w[1]), .out_zero(zero_w[1]), .out_err(err_w[1]),
      .clr_cnt(clr_cnt), .err_cnt(cnt1));

   onehot_encoder_pipe #(.IN_W(8), .MODE(0), .PRIO_MSB(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_data(in_data), .out_valid(out_valid_w[2]), .out_ready(out_ready),
      .out_code(code_w[2]), .out_zero(zero_w[2]), .out_err(err_w[2]),
      .clr_cnt(clr_cnt), .err_cnt(cnt2));

   function automatic int cnt_of(input int d);
      case (d)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level encoding: index of highest or lowest set bit by arithmetic.
   task automatic encode(input int v, input int mode, input int prio,
                         output int code, output bit zero, output bit err);
      int n;
      n    = $countones(v[7:0]);
      zero = (n == 0);
      err  = (n > 1) && (mode == 0);
      if (n == 0)    code = 0;
      else if (prio) code = $clog2(v + 1) - 1;
      else           code = $clog2(v & -v);
   endtask

   int m_valid [3];
   int m_code  [3];
   bit m_zero  [3];
   bit m_err   [3];
   int m_cnt   [3];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            m_valid[d] = 0; m_code[d] = 0; m_zero[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
         end else begin
            bit acc;
            int c;
            bit z, e;
            acc = in_valid && (m_valid[d] == 0 || out_ready);
            encode(int'(in_data), cfg_mode[d], cfg_prio[d], c, z, e);
            if (acc) begin
               m_valid[d] = 1; m_code[d] = c; m_zero[d] = z; m_err[d] = e;
            end else if (out_ready) begin
               m_valid[d] = 0;
            end
            if (clr_cnt) m_cnt[d] = 0;
            else if (acc && e && m_cnt[d] < cfg_cmax[d]) m_cnt[d] = m_cnt[d] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            check($sformatf("in_ready[%0d]", d), int'(in_ready_w[d]),
                  (m_valid[d] == 0 || out_ready) ? 1 : 0);
            check($sformatf("out_valid[%0d]", d), int'(out_valid_w[d]), m_valid[d]);
            if (m_valid[d] != 0) begin
               check($sformatf("out_code[%0d]", d), int'(code_w[d]), m_code[d]);
               check($sformatf("out_zero[%0d]", d), int'(zero_w[d]), int'(m_zero[d]));
               check($sformatf("out_err[%0d]", d), int'(err_w[d]), int'(m_err[d]));
            end
            check($sformatf("err_cnt[%0d]", d), cnt_of(d), m_cnt[d]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc();
      check("reset out_valid", int'(out_valid_w[0]), 0);
      check("reset out_code", int'(code_w[0]), 0);
      check("reset err_cnt", int'(cnt0), 0);
      #2 rst_n = 1'b1;
      cyc();

      // One-hot words, back to back.
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 8'b0000_0001; cyc(); check("oh code0", int'(code_w[0]), 0);
      in_data = 8'b0001_0000; cyc(); check("oh code4", int'(code_w[0]), 4);
      in_data = 8'b1000_0000; cyc(); check("oh code7", int'(code_w[0]), 7);
      check("oh err", int'(err_w[0]), 0);
      check("oh zero", int'(zero_w[0]), 0);
      check("oh cnt", int'(cnt0), 0);

      // Multi-hot then zero in strict mode.
      in_data = 8'b0010_0100; cyc();
      check("mh code", int'(code_w[0]), 5);
      check("mh err", int'(err_w[0]), 1);
      check("mh cnt", int'(cnt0), 1);
      in_data = 8'b0000_0000; cyc();
      check("zero code", int'(code_w[0]), 0);
      check("zero flag", int'(zero_w[0]), 1);
      check("zero err", int'(err_w[0]), 0);
      check("zero cnt", int'(cnt0), 1);

      // Priority mode, lowest bit wins.
      in_data = 8'b1010_1000; cyc();
      check("prio code", int'(code_w[1]), 3);
      check("prio err", int'(err_w[1]), 0);
      check("prio cnt", int'(cnt1), 0);

      // Backpressure.
      in_data = 8'b0100_0000; cyc();
      out_ready = 1'b0; in_data = 8'b0000_0011;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp code", int'(code_w[0]), 6);
         check("bp in_ready", int'(in_ready_w[0]), 0);
         check("bp valid", int'(out_valid_w[0]), 1);
      end
      out_ready = 1'b1;
      #1 check("bp release in_ready", int'(in_ready_w[0]), 1);
      cyc();
      check("bp next code", int'(code_w[0]), 1);
      check("bp next err", int'(err_w[0]), 1);
      in_valid = 1'b0; cyc();
      check("drain valid", int'(out_valid_w[0]), 0);

      // Saturation of the 2-bit counter, then clear beating an increment.
      clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
      check("clr cnt2", int'(cnt2), 0);
      in_valid = 1'b1; in_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("sat cnt2", int'(cnt2), (i < 3) ? i + 1 : 3);
      end
      clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
      check("clr prio cnt2", int'(cnt2), 0);
      check("clr prio cnt0", int'(cnt0), 0);

      // Asynchronous reset while stalled.
      in_data = 8'h81; cyc();
      out_ready = 1'b0; in_valid = 1'b0; cyc();
      check("pre-rst valid", int'(out_valid_w[0]), 1);
      #2 rst_n = 1'b0;
      #1 check("async rst valid", int'(out_valid_w[0]), 0);
      check("async rst cnt", int'(cnt0), 0);
      cyc(); cyc();
      #2 rst_n = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'b0000_0010;
      cyc();
      check("post-rst code", int'(code_w[0]), 1);
      check("post-rst valid", int'(out_valid_w[0]), 1);

      // Randomised traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_cnt   = ($urandom_range(0, 49) == 0);
         r = $urandom_range(0, 3);
         if (r == 0)      in_data = 8'h00;
         else if (r == 1) in_data = 8'(1 << $urandom_range(0, 7));
         else             in_data = 8'($urandom);
         cyc();
      end
      in_valid = 1'b0; clr_cnt = 1'b0;
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
